// File: rtl/cla_bist_nbit.sv
// cla_bist_nbit: parametrised carry-lookahead adder with a registered result
// and a built-in self-test engine. The engine has an LFSR pattern source, a
// MISR response compactor and an IDLE/RUN/DONE controller.
// Optional build macro CLA_FAULT_INJECT_EN adds input fault_inj_i. While
// fault_inj_i is high, it forces internal carry c[FAULT_BIT] to 0.
module cla_bist_nbit #(
  parameter int               WIDTH       = 6,
  parameter int               BIST_CYCLES = 64,
  parameter logic [2*WIDTH:0] LFSR_SEED   = 13'h0001,
  parameter logic [2*WIDTH:0] LFSR_MASK   = 13'h100D,
  parameter logic [WIDTH:0]   MISR_MASK   = 7'h60,
  parameter logic [WIDTH:0]   GOLDEN_SIG  = 7'h00,
  parameter int               FAULT_BIT   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  input  logic             bist_start_i,
  output logic             bist_busy_o,
  output logic             bist_done_o,
  output logic             bist_pass_o,
  output logic [WIDTH:0]   signature_o
`ifdef CLA_FAULT_INJECT_EN
  ,
  input  logic             fault_inj_i
`endif
);

  localparam int PW = 2 * WIDTH + 1;
  localparam int CW = (BIST_CYCLES > 1) ? $clog2(BIST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIST_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [PW-1:0]  pat_q;
  logic [WIDTH:0] sig_q;
  logic [CW-1:0]  cnt_q;
  logic           pass_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Core operands: the pattern register drives the adder while the self-test runs
  logic [WIDTH-1:0] core_a;
  logic [WIDTH-1:0] core_b;
  logic             core_cin;
  logic             in_run;

  assign in_run   = (state_q == RUN);
  assign core_a   = in_run ? pat_q[WIDTH-1:0]       : a_i;
  assign core_b   = in_run ? pat_q[2*WIDTH-1:WIDTH] : b_i;
  assign core_cin = in_run ? pat_q[2*WIDTH]         : cin_i;

  // Generate and propagate terms, one per bit
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_gp
      assign g[gi] = core_a[gi] & core_b[gi];
      assign p[gi] = core_a[gi] ^ core_b[gi];
    end
  endgenerate

  // Carry chain. c[i] is the carry into bit i. A forced carry also feeds the higher bits.
  logic [WIDTH:0] c;

  always_comb begin
    logic carry;
    carry = core_cin;
    c     = '0;
    for (int i = 0; i < WIDTH; i++) begin
`ifdef CLA_FAULT_INJECT_EN
      if ((i == FAULT_BIT) && fault_inj_i) begin
        carry = 1'b0;
      end
`endif
      c[i]  = carry;
      carry = g[i] | (p[i] & carry);
    end
    c[WIDTH] = carry;
  end

  logic [WIDTH-1:0] core_sum;
  logic [WIDTH:0]   core_res;

  assign core_sum = p ^ c[WIDTH-1:0];
  assign core_res = {c[WIDTH], core_sum};

  // Next pattern and next signature while running
  logic [PW-1:0]  pat_next;
  logic [WIDTH:0] sig_next;

  assign pat_next = {pat_q[PW-2:0], ^(pat_q & LFSR_MASK)};
  assign sig_next = {sig_q[WIDTH-1:0], ^(sig_q & MISR_MASK)} ^ core_res;

  // A start request takes priority over a functional beat in the same cycle
  logic accept;

  assign in_ready_o = !in_run && !bist_start_i;
  assign accept     = in_valid_i && in_ready_o;

  // BIST controller: state, pattern, signature, count and verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= LFSR_SEED;
      sig_q   <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bist_start_i) begin
            state_q <= RUN;
            pat_q   <= LFSR_SEED;
            sig_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
          end
        end
        RUN: begin
          sig_q <= sig_next;
          pat_q <= pat_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q <= DONE;
            pass_q  <= (sig_next == GOLDEN_SIG);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Functional result register: capture on an accepted beat, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        sum_q  <= core_sum;
        cout_q <= core_res[WIDTH];
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign bist_busy_o = in_run;
  assign bist_done_o = (state_q == DONE);
  assign bist_pass_o = pass_q;
  assign signature_o = sig_q;

endmodule

// File: tb/tb_cla_bist_nbit.sv
// Self-checking bench for cla_bist_nbit. A second instance uses a golden
// signature that differs by one bit, so the failing verdict is checked too.
module tb_cla_bist_nbit;

  localparam int             W     = 6;
  localparam int             BC    = 64;
  localparam logic [2*W:0]   SEED  = 13'h0001;
  localparam logic [2*W:0]   LMASK = 13'h100D;
  localparam logic [W:0]     MMASK = 7'h60;

  // Reference signature: apply BC patterns, add them arithmetically and compact the results
  function automatic logic [W:0] ref_signature();
    logic [2*W:0] pat;
    logic [W:0]   s;
    int           total;
    pat = SEED;
    s   = '0;
    for (int k = 0; k < BC; k++) begin
      total = int'(pat[W-1:0]) + int'(pat[2*W-1:W]) + int'(pat[2*W]);
      s     = {s[W-1:0], ^(s & MMASK)} ^ total[W:0];
      pat   = {pat[2*W-1:0], ^(pat & LMASK)};
    end
    return s;
  endfunction

  localparam logic [W:0] GOLD = ref_signature();

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic [W-1:0] sum;
  logic         cout;
  logic         bist_start;
  logic         bist_busy;
  logic         bist_done;
  logic         bist_pass;
  logic [W:0]   signature;
`ifdef CLA_FAULT_INJECT_EN
  logic         fault_inj;
`endif

  logic         in_ready_b;
  logic         out_valid_b;
  logic [W-1:0] sum_b;
  logic         cout_b;
  logic         bist_busy_b;
  logic         bist_done_b;
  logic         bist_pass_b;
  logic [W:0]   signature_b;

  int n_vec;
  int n_err;

  cla_bist_nbit #(
    .WIDTH(W), .BIST_CYCLES(BC), .LFSR_SEED(SEED), .LFSR_MASK(LMASK),
    .MISR_MASK(MMASK), .GOLDEN_SIG(GOLD), .FAULT_BIT(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .cin_i(cin), .out_valid_o(out_valid), .sum_o(sum),
    .cout_o(cout), .bist_start_i(bist_start), .bist_busy_o(bist_busy),
    .bist_done_o(bist_done), .bist_pass_o(bist_pass), .signature_o(signature)
`ifdef CLA_FAULT_INJECT_EN
    , .fault_inj_i(fault_inj)
`endif
  );

  cla_bist_nbit #(
    .WIDTH(W), .BIST_CYCLES(BC), .LFSR_SEED(SEED), .LFSR_MASK(LMASK),
    .MISR_MASK(MMASK), .GOLDEN_SIG(GOLD ^ 7'h01), .FAULT_BIT(1)
  ) dut_bad (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready_b),
    .a_i(a), .b_i(b), .cin_i(cin), .out_valid_o(out_valid_b), .sum_o(sum_b),
    .cout_o(cout_b), .bist_start_i(bist_start), .bist_busy_o(bist_busy_b),
    .bist_done_o(bist_done_b), .bist_pass_o(bist_pass_b), .signature_o(signature_b)
`ifdef CLA_FAULT_INJECT_EN
    , .fault_inj_i(fault_inj)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values();
    chk("rst_sum",       32'(sum),       32'(0));
    chk("rst_cout",      32'(cout),      32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy",      32'(bist_busy), 32'(0));
    chk("rst_done",      32'(bist_done), 32'(0));
    chk("rst_pass",      32'(bist_pass), 32'(0));
    chk("rst_signature", 32'(signature), 32'(0));
    chk("rst_in_ready",  32'(in_ready),  32'(1));
  endtask

  // Pulse bist_start and count busy cycles. Stop early when stop_at is nonzero.
  // Every busy cycle must block functional traffic and hold the previous result.
  task automatic run_bist(input int stop_at, input logic [W:0] held, output int busy_cycles);
    bist_start = 1'b1;
    tick();
    bist_start = 1'b0;
    in_valid   = 1'b0;
    busy_cycles = 0;
    for (int t = 0; t < 300; t++) begin
      if (!bist_busy) break;
      busy_cycles++;
      chk("run_in_ready",  32'(in_ready),      32'(0));
      chk("run_out_valid", 32'(out_valid),     32'(0));
      chk("run_hold",      32'({cout, sum}),   32'(held));
      if (busy_cycles == stop_at) return;
      tick();
    end
  endtask

  logic [W:0] exp_res;
  int         cyc;

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    bist_start = 1'b0;
`ifdef CLA_FAULT_INJECT_EN
    fault_inj  = 1'b0;
`endif
    #12;
    check_reset_values();
    rst_n = 1'b1;
    tick();

    // Directed wrap-around add, then an idle cycle
    a = 6'h3F; b = 6'h01; cin = 1'b0; in_valid = 1'b1;
    tick();
    chk("add_valid", 32'(out_valid), 32'(1));
    chk("add_sum",   32'(sum),       32'(6'h00));
    chk("add_cout",  32'(cout),      32'(1));
    exp_res  = 7'h40;
    in_valid = 1'b0;
    tick();
    chk("idle_valid", 32'(out_valid),   32'(0));
    chk("idle_hold",  32'({cout, sum}), 32'(exp_res));

    // Back-to-back random beats
    for (int k = 0; k < 16; k++) begin
      a = 6'($urandom); b = 6'($urandom); cin = 1'($urandom); in_valid = 1'b1;
      exp_res = 7'((int'(a) + int'(b) + int'(cin)) % 128);
      tick();
      $display("beat %0d: a=%0h b=%0h cin=%0d -> cout=%0d sum=%0h (want %0h)",
               k, a, b, cin, cout, sum, exp_res);
      chk("stream_valid", 32'(out_valid),   32'(1));
      chk("stream_res",   32'({cout, sum}), 32'(exp_res));
    end
    in_valid = 1'b0;

    // BIST start collides with a functional beat: BIST wins
    a = 6'h15; b = 6'h2A; in_valid = 1'b1; bist_start = 1'b1;
    #1;
    chk("collide_in_ready", 32'(in_ready), 32'(0));
    run_bist(0, exp_res, cyc);
    $display("bist run: busy for %0d cycles, signature %0h (want %0h)", cyc, signature, GOLD);
    chk("bist_cycles",   32'(cyc),         32'(BC));
    chk("bist_done",     32'(bist_done),   32'(1));
    chk("bist_pass",     32'(bist_pass),   32'(1));
    chk("bist_sig",      32'(signature),   32'(GOLD));
    chk("bad_done",      32'(bist_done_b), 32'(1));
    chk("bad_pass",      32'(bist_pass_b), 32'(0));
    chk("bad_sig",       32'(signature_b), 32'(GOLD));
    chk("done_in_ready", 32'(in_ready),    32'(1));
    chk("done_hold",     32'({cout, sum}), 32'(exp_res));

    // Functional beat while in DONE: the verdict and signature must not change
    a = 6'($urandom); b = 6'($urandom); cin = 1'($urandom); in_valid = 1'b1;
    exp_res = 7'((int'(a) + int'(b) + int'(cin)) % 128);
    tick();
    in_valid = 1'b0;
    chk("done_beat_valid", 32'(out_valid),   32'(1));
    chk("done_beat_res",   32'({cout, sum}), 32'(exp_res));
    chk("done_keep_done",  32'(bist_done),   32'(1));
    chk("done_keep_pass",  32'(bist_pass),   32'(1));
    chk("done_keep_sig",   32'(signature),   32'(GOLD));

    // Reset in the middle of a run, then a clean rerun
    run_bist(20, exp_res, cyc);
    chk("abort_cycles", 32'(cyc), 32'(20));
    rst_n = 1'b0;
    #1;
    check_reset_values();
    #2;
    rst_n = 1'b1;
    tick();
    exp_res = '0;
    run_bist(0, exp_res, cyc);
    $display("bist rerun: busy for %0d cycles, signature %0h (want %0h)", cyc, signature, GOLD);
    chk("rerun_cycles", 32'(cyc),       32'(BC));
    chk("rerun_done",   32'(bist_done), 32'(1));
    chk("rerun_pass",   32'(bist_pass), 32'(1));
    chk("rerun_sig",    32'(signature), 32'(GOLD));

`ifdef CLA_FAULT_INJECT_EN
    // Carry into bit 1 stuck at 0: 1+1 loses its carry entirely
    fault_inj = 1'b1;
    a = 6'h01; b = 6'h01; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("fault_valid", 32'(out_valid), 32'(1));
    chk("fault_sum",   32'(sum),       32'(6'h00));
    chk("fault_cout",  32'(cout),      32'(0));
    run_bist(0, 7'h00, cyc);
    chk("fault_cycles", 32'(cyc),       32'(BC));
    chk("fault_done",   32'(bist_done), 32'(1));
    chk("fault_pass",   32'(bist_pass), 32'(0));
    fault_inj = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cla_bist_nbit.md
Name: cla_bist_nbit

Overview:
- Parametrised N-bit carry-lookahead adder with a registered output and an integrated BIST engine.
- BIST engine: LFSR pattern generator, MISR response compactor, and a controller FSM.
- Functional mode: one registered add per accepted beat. BIST mode: self-test of the CLA datapath with pass/fail against a golden signature.
- Sits in the datapath as the successor to the fixed 6-bit CLA. Testable standalone or under a top-level BIST controller.

Parameters:
- WIDTH, 6: adder operand width, ≥2.
- BIST_CYCLES, 64: number of patterns applied per BIST run, ≥1.
- LFSR_SEED, 13'h0001: initial pattern register value, width 2*WIDTH+1. Must be nonzero.
- LFSR_MASK, 13'h100D: feedback tap mask, width 2*WIDTH+1. Default is x^13+x^4+x^3+x+1.
- MISR_MASK, 7'h60: MISR feedback tap mask, width WIDTH+1.
- GOLDEN_SIG, 7'h00: expected final MISR value, width WIDTH+1.
- FAULT_BIT, 1: carry index forced stuck-at-0 under fault injection, 1..WIDTH-1.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- in_valid, in, 1: functional operands valid.
- in_ready, out, 1: block accepts a functional beat.
- a, in, WIDTH: operand A.
- b, in, WIDTH: operand B.
- cin, in, 1: carry in.
- out_valid, out, 1: sum/cout valid.
- sum, out, WIDTH: registered sum.
- cout, out, 1: registered carry out.
- bist_start, in, 1: start or restart a BIST run.
- bist_busy, out, 1: FSM in RUN.
- bist_done, out, 1: FSM in DONE.
- bist_pass, out, 1: final signature equals GOLDEN_SIG. Valid while bist_done.
- signature, out, WIDTH+1: current MISR contents.

Behaviour:
- Reset (async, rst_n=0): sum=0, cout=0, out_valid=0, state=IDLE, P=LFSR_SEED, S=0, cnt=0, bist_pass=0. Derived outputs: bist_busy=0, bist_done=0, signature=0, in_ready=1.
- CLA core is combinational:
  - g[i]=a&b, p[i]=a^b.
  - c[0]=cin, c[i+1]=g[i]|(p[i]&c[i]).
  - sum[i]=p[i]^c[i], cout=c[WIDTH].
  - Result is the WIDTH+1 value {cout,sum}, modulo 2^(WIDTH+1).
- Core operand mux: functional a/b/cin in IDLE and DONE. In RUN: a=P[WIDTH-1:0], b=P[2W-1:WIDTH], cin=P[2W].
- in_ready = (state!=RUN) && !bist_start.
- Functional handshake: beat accepted when in_valid && in_ready. Next edge: sum/cout register the core result and out_valid=1.
- Cycle with no accepted beat: out_valid=0 next edge; sum/cout hold their last values.
- Latency is 1 cycle. Throughput is 1 beat per cycle. There is no output backpressure.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on bist_start. Load P=LFSR_SEED, S=0, cnt=0, bist_pass=0.
  - RUN, each cycle:
    - S <= {S[W-1:0], ^(S&MISR_MASK)} ^ {cout_core,sum_core}.
    - P <= {P[2W-1:0], ^(P&LFSR_MASK)}.
    - cnt++.
    - When cnt==BIST_CYCLES-1, this last update is taken and the FSM goes to DONE.
    - bist_start is ignored in RUN.
  - DONE: bist_pass = (S==GOLDEN_SIG), registered on entry. S and bist_pass hold. Functional beats are allowed. bist_start → RUN with a fresh load.
- During RUN: out_valid=0, and sum/cout hold their pre-BIST values.
- in_valid together with bist_start in IDLE/DONE: BIST wins and the beat is not accepted (in_ready=0).
- BIST_CYCLES=1: RUN lasts exactly 1 cycle.
- rst_n low mid-RUN: immediate return to IDLE and all reset values. No partial signature is retained.
- signature output = S at all times.

Optional Feature:
- Macro CLA_FAULT_INJECT_EN.
- When defined:
  - Extra input port fault_inj, 1 bit.
  - While fault_inj=1, internal carry c[FAULT_BIT] is forced to 0 in both functional and BIST modes.
  - sum and propagation use the forced value.
- When undefined: no port and no forcing logic. Core is exactly as above.

Test Plan:
- Reset then functional add, a=6'h3F, b=6'h01, cin=0, in_valid=1 → next cycle out_valid=1, sum=6'h00, cout=1. Idle cycle after it → out_valid=0, sum/cout held.
- Functional stream of 16 back-to-back random beats → each result equals a+b+cin, 1-cycle latency, no gaps.
- BIST run, defaults, GOLDEN_SIG set from the bench LFSR/MISR model:
  - bist_start pulse → bist_busy=1 for exactly 64 cycles, then bist_done=1, bist_pass=1, signature matches the model.
  - in_ready=0 throughout the run.
- Same run with GOLDEN_SIG off by one bit → bist_done=1, bist_pass=0.
- rst_n asserted at RUN cycle 20 → all outputs at reset values immediately. A new bist_start produces the full-run signature identical to the uninterrupted run.
- CLA_FAULT_INJECT_EN defined, fault_inj=1, FAULT_BIT=1:
  - Functional a=6'h01, b=6'h01, cin=0 → sum=6'h00, cout=0.
  - BIST → bist_pass=0.
